// File: rtl/aes_decrypt_top.sv
`timescale 1ns/1ps
`default_nettype none
// aes_decrypt_top: iterative AES-128 inverse cipher with on-the-fly reverse key schedule.
// Rev 1.0

package aes_decrypt_pkg;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
endpackage

module AES_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  import aes_decrypt_pkg::*;
  logic [7:0] inv;
  assign inv   = ginv(in_i);
  assign out_o = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
endmodule

module AES_inv_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  import aes_decrypt_pkg::*;
  logic [7:0] pre;
  assign pre   = rotl8(in_i, 1) ^ rotl8(in_i, 3) ^ rotl8(in_i, 6) ^ 8'h05;
  assign out_o = ginv(pre);
endmodule

module aes_decrypt_top (
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid
);
  import aes_decrypt_pkg::*;

  typedef enum logic [1:0] {S_IDLE, S_KEYEXP, S_ADDK, S_ROUND} state_e;

  state_e       fsm_q, fsm_d;
  logic [127:0] state_q, state_d, key_q, key_d, dout_q, dout_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         valid_q, valid_d;

  logic [127:0] isr, isb, t, imc;
  logic [31:0]  sb_in, sb_out, rcon_word;
  logic [7:0]   rcon;
  logic [31:0]  f0, f1, f2, f3, v0, v1, v2, v3;

  // InvShiftRows: row r rotates right by r columns.
  always_comb begin
    isr = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        isr[127-8*(4*c+r) -: 8] = state_q[127-8*(4*((c+4-r)%4)+r) -: 8];
  end

  for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
    AES_inv_sbox u_isb (.in_i(isr[127-8*i -: 8]), .out_o(isb[127-8*i -: 8]));
  end

  assign t = isb ^ key_q;

  always_comb begin
    imc = '0;
    for (int c = 0; c < 4; c++)
      imc[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
  end

  // Backward step needs SubWord of the regenerated w3, which is w2^w3 of the current key.
  assign sb_in = (fsm_q == S_KEYEXP) ? key_q[31:0] : (key_q[63:32] ^ key_q[31:0]);

  for (genvar j = 0; j < 4; j++) begin : g_key_sbox
    AES_sbox u_sb (.in_i(sb_in[31-8*((j+1)%4) -: 8]), .out_o(sb_out[31-8*j -: 8]));
  end

  always_comb begin
    case (rnd_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end
  assign rcon_word = {rcon, 24'h0};

  assign f0 = key_q[127:96] ^ sb_out ^ rcon_word;
  assign f1 = key_q[95:64] ^ f0;
  assign f2 = key_q[63:32] ^ f1;
  assign f3 = key_q[31:0]  ^ f2;

  assign v3 = key_q[31:0]  ^ key_q[63:32];
  assign v2 = key_q[63:32] ^ key_q[95:64];
  assign v1 = key_q[95:64] ^ key_q[127:96];
  assign v0 = key_q[127:96] ^ sb_out ^ rcon_word;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (AES_en) begin
          state_d = AES_data_in;
          key_d   = AES_key_in;
          rnd_d   = 4'd1;
          fsm_d   = S_KEYEXP;
        end
      end
      S_KEYEXP: begin
        key_d = {f0, f1, f2, f3};
        // rnd stays at 10 so ADDK indexes Rcon[10] directly.
        if (rnd_q == 4'd10) fsm_d = S_ADDK;
        else                rnd_d = rnd_q + 4'd1;
      end
      S_ADDK: begin
        state_d = state_q ^ key_q;
        key_d   = {v0, v1, v2, v3};
        rnd_d   = 4'd9;
        fsm_d   = S_ROUND;
      end
      S_ROUND: begin
        if (rnd_q != 4'd0) begin
          state_d = imc;
          key_d   = {v0, v1, v2, v3};
          rnd_d   = rnd_q - 4'd1;
        end else begin
          dout_d  = t;
          valid_d = 1'b1;
          fsm_d   = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign AES_data_out       = dout_q;
  assign AES_data_out_valid = valid_q;
endmodule

`default_nettype wire

// File: doc/aes_decrypt_top.md
# aes_decrypt_top

Iterative AES-128 inverse cipher: the decryption counterpart of `AES_top`, taking a 128-bit ciphertext and the original cipher key and returning the plaintext. It expands the key forward to round key 10, then runs the ten inverse rounds and regenerates round keys backwards on the fly, so no key RAM is needed. It sits beside `AES_top` and shares its port convention and byte ordering, so an `AES_top` output can be fed straight back for a round trip. Combinational sub-blocks: 16× `AES_inv_sbox`, 4× `AES_sbox` (shared by forward and inverse key schedule).

## Interface
- No parameters (AES-128 only).
- `AES_clk` input 1: single clock, rising edge.
- `AES_rst_n` input 1: asynchronous, active-low reset.
- `AES_en` input 1: start request, sampled only in IDLE.
- `AES_data_in` input 128: ciphertext; byte 0 = [127:120], column-major (FIPS-197 order).
- `AES_key_in` input 128: cipher key (round key 0), same byte order.
- `AES_data_out` output 128: plaintext, held until the next completion.
- `AES_data_out_valid` output 1: one-cycle pulse when `AES_data_out` updates.

## Operation
- Registers: `state_reg`[127:0], `key_reg`[127:0], `rnd`[3:0], FSM state, output registers.
- IDLE: if `AES_en`=1 at an edge, capture `state_reg`<=`AES_data_in` and `key_reg`<=`AES_key_in`, set `rnd`<=1, go to KEYEXP. Otherwise hold.
- KEYEXP (10 cycles, `rnd`=1..10): `key_reg`<=fwd(`key_reg`,Rcon[`rnd`]), `rnd`++. On `rnd`=10, go to ADDK; `key_reg` then holds K10.
- Forward step fwd: w0'=w0^SubWord(RotWord(w3))^{Rcon,24'h0}; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
- ADDK (1 cycle): `state_reg`<=`state_reg`^K10; `key_reg`<=inv(K10,Rcon[10]); `rnd`<=9; go to ROUND.
- Inverse step inv(K,Rcon[i]): w3'=w3^w2; w2'=w2^w1; w1'=w1^w0; w0'=w0^SubWord(RotWord(w3'))^{Rcon[i],24'h0}.
- ROUND (10 cycles, `rnd`=9..0): t=InvSubBytes(InvShiftRows(`state_reg`))^`key_reg`. For `rnd`≥1: `state_reg`<=InvMixColumns(t), `key_reg`<=inv(`key_reg`,Rcon[`rnd`]), `rnd`--. For `rnd`=0: `AES_data_out`<=t, `AES_data_out_valid`<=1, go to IDLE.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, taken from a 10-entry lookup indexed by `rnd`. The 4 forward S-boxes are muxed between RotWord(w3) (KEYEXP) and RotWord(w2^w3) (ADDK/ROUND).
- InvMixColumns uses the GF(2^8) multipliers {0e,0b,0d,09} built from xtime chains, with the reduction polynomial 0x11b.
- `AES_en`, `AES_data_in` and `AES_key_in` are ignored outside IDLE: changes mid-operation have no effect on the running block.
- If `AES_en` stays high, a new operation starts on the edge after valid. Every start produces exactly one valid pulse.

## Timing
- Reset (asynchronous, any state): FSM→IDLE; `AES_data_out`=0; `AES_data_out_valid`=0; `state_reg`, `key_reg` and `rnd` cleared. An operation interrupted by reset produces no valid pulse. The first start after release needs `AES_en` sampled at a rising edge with `AES_rst_n`=1.
- Let E0 be the edge that samples `AES_en`=1 in IDLE:
  - KEYEXP: E1–E10.
  - ADDK: E11.
  - ROUND: E12–E21.
  - E21 registers `AES_data_out` and sets valid. Valid is high from E21 to E22, and E22 clears it.
- Latency is 21 cycles, start edge to valid edge. Throughput is one block per 22 cycles with `AES_en` held high (E22 is the next possible start).
- `AES_data_out` changes only at valid edges.

## Test plan
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, data 3925841d02dc09fbdc118597196a0b32 → out 3243f6a8885a308d313198a2e0370734, valid exactly 21 cycles after the start edge, width one cycle.
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, data 69c4e0d86a7b0430d8cdb78070b4c55a → out 00112233445566778899aabbccddeeff. Also check K10 = 13111d7fe3944a17f307a78b4d2b30c5 after E10.
- Round trip: `AES_top` encrypts 00000059_00000000_00000000_00000000 under key aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc; feeding its output and the same key here → original data recovered.
- Busy isolation: start C.1, then change `AES_data_in`/`AES_key_in` every cycle and toggle `AES_en` during E1–E20 → C.1 result unchanged, a single valid pulse.
- Back-to-back: hold `AES_en`=1 with two vectors presented at E0 and E22 → two valid pulses 22 cycles apart, each with the correct plaintext.
- Reset mid-operation: assert `AES_rst_n`=0 asynchronously at ~E8 → `AES_data_out`=0 and valid=0 immediately, no pulse. After release, B vector → correct result at 21-cycle latency.
